// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ID/EX bundle layout, stall vector encoding,
// and the per-cycle action decode used by the inter-stage registers.
package pipe_pkg;

  localparam int unsigned STALL_W = 6;

  // Stall vector bit values.
  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] link_addr;
    logic        in_dslot;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [9:0]  rsvd;
  } id_ex_bus_t;

  localparam int unsigned ID_EX_W   = $bits(id_ex_bus_t);
  localparam id_ex_bus_t  ID_EX_NOP = '0;

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_FLUSH,
    ACT_BUBBLE,
    ACT_HOLD,
    ACT_ADVANCE
  } stage_act_e;

  // Strict priority: reset, flush, then the upstream/downstream stall pair.
  // Upstream running with downstream stopped is illegal but still advances.
  function automatic stage_act_e decode_act(input logic rst, input logic flush,
                                            input logic u, input logic d);
    if (rst)
      return ACT_RESET;
    else if (flush)
      return ACT_FLUSH;
    else if (u == Stop && d == NoStop)
      return ACT_BUBBLE;
    else if (u == Stop && d == Stop)
      return ACT_HOLD;
    else
      return ACT_ADVANCE;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; reset overrides clear,
// clear overrides increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Count events, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: payload + valid, stall/flush
// handling, delay-slot feedback and saturating perf event counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W                 = ID_EX_W,
  parameter int unsigned STALL_W                = pipe_pkg::STALL_W,
  parameter int unsigned STAGE_IDX              = 2,
  parameter int unsigned CNT_W                  = 16,
  parameter logic [DATA_W-1:0] NOP_PAYLOAD      = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               cnt_clr,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_payload,
  input  logic               in_next_dslot,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_payload,
  output logic               dslot_fb,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  logic       u;
  logic       d;
  logic       stall_unused;
  stage_act_e act;

  assign u = stall[STAGE_IDX];
  assign d = stall[STAGE_IDX+1];

  // Only two bits of the global vector matter to this stage.
  assign stall_unused = ^stall;

  // Resolve this cycle's action from the priority order.
  always_comb begin
    act = decode_act(rst, flush, u, d);
  end

  // Stage register update for the selected action.
  always_ff @(posedge clk) begin
    unique case (act)
      ACT_RESET, ACT_FLUSH: begin
        out_valid   <= 1'b0;
        out_payload <= NOP_PAYLOAD;
        dslot_fb    <= 1'b0;
      end
      ACT_BUBBLE: begin
        // dslot_fb deliberately kept so a branch stalled in decode still
        // marks its delay slot once it resumes.
        out_valid   <= 1'b0;
        out_payload <= NOP_PAYLOAD;
      end
      ACT_HOLD: begin
        out_valid   <= out_valid;
        out_payload <= out_payload;
        dslot_fb    <= dslot_fb;
      end
      ACT_ADVANCE: begin
        out_valid   <= in_valid;
        out_payload <= in_valid ? in_payload : NOP_PAYLOAD;
        dslot_fb    <= in_next_dslot;
      end
      default: begin
        out_valid   <= 1'b0;
        out_payload <= NOP_PAYLOAD;
        dslot_fb    <= 1'b0;
      end
    endcase
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (act == ACT_HOLD),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (act == ACT_BUBBLE),
    .cnt (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc ((act == ACT_FLUSH) && out_valid),
    .cnt (flush_cnt)
  );

  // Upstream advancing into a stopped downstream stage is a controller bug.
  a_no_advance_into_stall: assert property (@(posedge clk) disable iff (rst) !(!u && d));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed scoreboard bench for pipe_stage_reg (CNT_W=4 to reach saturation).
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int unsigned DW = ID_EX_W;
  localparam int unsigned CW = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [5:0]         stall;
  logic               flush;
  logic               cnt_clr;
  logic               in_valid;
  logic [DW-1:0]      in_payload;
  logic               in_next_dslot;
  logic               out_valid;
  logic [DW-1:0]      out_payload;
  logic               dslot_fb;
  logic [CW-1:0]      stall_cnt;
  logic [CW-1:0]      bubble_cnt;
  logic [CW-1:0]      flush_cnt;

  pipe_stage_reg #(
    .DATA_W    (DW),
    .STALL_W   (6),
    .STAGE_IDX (2),
    .CNT_W     (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .cnt_clr       (cnt_clr),
    .in_valid      (in_valid),
    .in_payload    (in_payload),
    .in_next_dslot (in_next_dslot),
    .out_valid     (out_valid),
    .out_payload   (out_payload),
    .dslot_fb      (dslot_fb),
    .stall_cnt     (stall_cnt),
    .bubble_cnt    (bubble_cnt),
    .flush_cnt     (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic          v;
    logic [DW-1:0] p;
    logic          ds;
    logic [CW-1:0] sc;
    logic [CW-1:0] bc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [5:0] RUN  = 6'b000000;
  localparam logic [5:0] LUSE = 6'b000111;
  localparam logic [5:0] DSTL = 6'b001111;

  logic [DW-1:0] NOP, PA5, P1, P2, P3;
  id_ex_bus_t    b;

  task automatic chk(input string tag, input string what, input logic [DW-1:0] act,
                     input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", tag, what, act, req);
    end
  endtask

  // Drive one cycle of inputs and queue the state expected after that edge.
  task automatic step(input string tag, input logic r, input logic f, input logic c,
                      input logic [5:0] st, input logic iv, input logic [DW-1:0] ip,
                      input logic ids, input logic ev, input logic [DW-1:0] ep,
                      input logic eds, input int esc, input int ebc, input int efc);
    exp_t e;
    @(negedge clk);
    rst = r; flush = f; cnt_clr = c; stall = st;
    in_valid = iv; in_payload = ip; in_next_dslot = ids;
    e.tag = tag; e.v = ev; e.p = ep; e.ds = eds;
    e.sc = CW'(esc); e.bc = CW'(ebc); e.fc = CW'(efc);
    exp_q.push_back(e);
  endtask

  // Monitor: every settled cycle with a pending expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.tag, "out_valid",   DW'(out_valid),  DW'(e.v));
        chk(e.tag, "out_payload", out_payload,     e.p);
        chk(e.tag, "dslot_fb",    DW'(dslot_fb),   DW'(e.ds));
        chk(e.tag, "stall_cnt",   DW'(stall_cnt),  DW'(e.sc));
        chk(e.tag, "bubble_cnt",  DW'(bubble_cnt), DW'(e.bc));
        chk(e.tag, "flush_cnt",   DW'(flush_cnt),  DW'(e.fc));
      end
    end
  end

  initial begin
    NOP = '0;
    PA5 = {4'h5, {23{8'hA5}}};
    b = '0; b.aluop = 8'h21; b.reg1 = 32'h0000_1111; b.inst = 32'h2008_0005; b.pc = 32'h0040_0000;
    P1 = b;
    b = '0; b.alusel = 3'd4; b.reg2 = 32'hDEAD_BEEF; b.wd = 5'd9; b.wreg = 1'b1; b.pc = 32'h0040_0004;
    P2 = b;
    b = '0; b.link_addr = 32'h0040_0010; b.in_dslot = 1'b1; b.rsvd = 10'h3FF; b.pc = 32'h0040_0008;
    P3 = b;

    rst = 1'b1; flush = 1'b0; cnt_clr = 1'b0; stall = RUN;
    in_valid = 1'b0; in_payload = '0; in_next_dslot = 1'b0;

    //   tag        rst  fl  clr  stall iv  payload ds   v   exp_p ds  sc bc fc
    step("reset0",  1, 0, 0, DSTL, 1, PA5, 1,   0, NOP, 0,  0, 0, 0);
    step("reset1",  1, 0, 0, LUSE, 1, PA5, 1,   0, NOP, 0,  0, 0, 0);
    step("adv_p1",  0, 0, 0, RUN,  1, P1,  0,   1, P1,  0,  0, 0, 0);
    step("adv_inv", 0, 0, 0, RUN,  0, P2,  1,   0, NOP, 1,  0, 0, 0);
    step("adv_p1b", 0, 0, 0, RUN,  1, P1,  1,   1, P1,  1,  0, 0, 0);
    step("bub1",    0, 0, 0, LUSE, 1, P2,  0,   0, NOP, 1,  0, 1, 0);
    step("bub2",    0, 0, 0, LUSE, 1, P2,  0,   0, NOP, 1,  0, 2, 0);
    step("adv_p2",  0, 0, 0, RUN,  1, P2,  0,   1, P2,  0,  0, 2, 0);
    step("hold1",   0, 0, 0, DSTL, 1, P3,  1,   1, P2,  0,  1, 2, 0);
    step("hold2",   0, 0, 0, DSTL, 1, P3,  1,   1, P2,  0,  2, 2, 0);
    step("hold3",   0, 0, 0, DSTL, 1, P3,  1,   1, P2,  0,  3, 2, 0);
    step("adv_p3",  0, 0, 0, RUN,  1, P3,  1,   1, P3,  1,  3, 2, 0);
    step("fl_hold", 0, 1, 0, DSTL, 1, P1,  1,   0, NOP, 0,  3, 2, 1);
    step("fl_idle", 0, 1, 0, RUN,  1, P1,  1,   0, NOP, 0,  3, 2, 1);
    step("adv_p1c", 0, 0, 0, RUN,  1, P1,  1,   1, P1,  1,  3, 2, 1);
    step("fl_bub",  0, 1, 0, LUSE, 1, P2,  1,   0, NOP, 0,  3, 2, 2);
    for (int i = 1; i <= 20; i++) begin
      step("sat_bub", 0, 0, 0, LUSE, 1, P2, 1,  0, NOP, 0,  3, (2 + i > 15) ? 15 : 2 + i, 2);
    end
    step("clr_bub", 0, 0, 1, LUSE, 1, P2,  1,   0, NOP, 0,  0, 0, 0);
    step("bub_aft", 0, 0, 0, LUSE, 1, P2,  1,   0, NOP, 0,  0, 1, 0);
    step("adv_p2b", 0, 0, 0, RUN,  1, P2,  1,   1, P2,  1,  0, 1, 0);
    step("hold_b",  0, 0, 0, DSTL, 0, P3,  0,   1, P2,  1,  1, 1, 0);
    step("rst_mid", 1, 0, 0, DSTL, 1, P3,  1,   0, NOP, 0,  0, 0, 0);
    step("rst_clr", 1, 0, 1, LUSE, 1, P3,  1,   0, NOP, 0,  0, 0, 0);
    step("adv_end", 0, 0, 0, RUN,  1, P3,  0,   1, P3,  0,  0, 0, 0);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
